// File: rtl/product_accum_pkg.sv
// Shared types and helpers for the product accumulator: FSM state encoding
// and the width of the per-batch product counter.
package product_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } accum_state_t;

  // Counter must represent 0..n_terms inclusive.
  function automatic int count_width(input int n_terms);
    return $clog2(n_terms + 1);
  endfunction

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Combinational accumulate step: widens the add by one bit, then clamps or
// wraps the result and reports whether the add overflowed SUM_W bits.
module sat_add #(
  parameter int IN_W     = 4,
  parameter int SUM_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic [SUM_W-1:0] acc,
  input  logic [IN_W-1:0]  addend,
  output logic [SUM_W-1:0] result,
  output logic             carry
);

  logic [SUM_W:0] wide;

  assign wide  = {1'b0, acc} + {{(SUM_W + 1 - IN_W){1'b0}}, addend};
  assign carry = wide[SUM_W];

  always_comb begin
    result = wide[SUM_W-1:0];
    if (carry && (SATURATE != 0)) result = '1;
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums fixed batches of N_TERMS unsigned products and hands each batch total
// to a valid/ready consumer, stalling the product stream while it waits.
module product_accumulator
  import product_accum_pkg::*;
#(
  parameter int IN_W     = 4,
  parameter int SUM_W    = 8,
  parameter int N_TERMS  = 4,
  parameter int SATURATE = 1,
  localparam int CNT_W   = count_width(N_TERMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic             clear,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             ovf,
  output logic [CNT_W-1:0] count
);

  accum_state_t     state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [SUM_W-1:0] add_result;
  logic             add_carry;

  sat_add #(
    .IN_W     (IN_W),
    .SUM_W    (SUM_W),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .acc    (sum_q),
    .addend (prod),
    .result (add_result),
    .carry  (add_carry)
  );

  // NOTE: every signal is given its hold value first so no path through the
  // case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (clear) begin
      state_d = ACCUM;
      sum_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (prod_valid) begin
            sum_d   = add_result;
            ovf_d   = ovf_q | add_carry;
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(N_TERMS - 1)) state_d = HOLD;
          end
        end
        HOLD: begin
          if (sum_ready) begin
            state_d = ACCUM;
            sum_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs come straight from the state flop; no input reaches them.
  assign prod_ready = (state_q == ACCUM);
  assign sum_valid  = (state_q == HOLD);
  assign sum        = sum_q;
  assign count      = count_q;
  assign ovf        = ovf_q;

endmodule
